// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
//   Sequencer for a 3x3 Sobel convolution datapath. Takes a raster pixel
//   stream over valid/ready and generates the line-buffer write controls,
//   the window shift enable and the interior-window flag. The flag is delayed
//   to line up with the convolution pipeline so that out_valid/out_last mark
//   the datapath results. busy/done frame each image.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   start      begin a frame (only honoured while idle)
//   in_valid   source presents a pixel
//   in_ready   controller accepts pixels (combinational from state)
//   lb_wr_en   line-buffer write strobe (registered)
//   lb_sel     line buffer being written, rotates 0,1,2 per row (registered)
//   lb_addr    column of the pixel being written (registered)
//   win_shift  shift the 3x3 window register by one column (registered)
//   win_valid  the window is a full interior 3x3 (registered)
//   out_valid  convolution result valid at the datapath output
//   out_last   accompanies the final out_valid of the frame
//   busy       controller is not idle
//   done       one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module sobel_window_ctrl #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int ADDR_W   = 6,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              lb_wr_en,
    output logic [1:0]        lb_sel,
    output logic [ADDR_W-1:0] lb_addr,
    output logic              win_shift,
    output logic              win_valid,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FL_W  = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [1:0]        r_row_sel;     // row mod 3, kept as its own counter
    logic [FL_W-1:0]   r_flush_cnt;

    logic              r_lb_wr_en;
    logic              r_win_shift;
    logic [1:0]        r_lb_sel;
    logic [ADDR_W-1:0] r_lb_addr;

    // Index 0 is the registered win_valid/last; index PIPE_LAT is the
    // datapath-aligned copy. One free-running shift register per flag.
    logic [PIPE_LAT:0] r_vld_pipe;
    logic [PIPE_LAT:0] r_last_pipe;

    logic              w_accept;
    logic              w_col_end;
    logic              w_last_pix;
    logic              w_interior;

    assign w_accept   = in_valid && (r_state == S_RUN);
    assign w_col_end  = (r_col == COL_W'(IMG_W - 1));
    assign w_last_pix = w_col_end && (r_row == ROW_W'(IMG_H - 1));
    assign w_interior = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_accept && w_last_pix) w_state_next = S_FLUSH;
            // FLUSH spans PIPE_LAT+1 cycles so the final result has left
            // the datapath before done is raised.
            S_FLUSH: if (r_flush_cnt == FL_W'(PIPE_LAT)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ pixel counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_row_sel   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_col     <= '0;
                r_row     <= '0;
                r_row_sel <= '0;
            end else if (w_accept) begin
                if (w_col_end) begin
                    r_col     <= '0;
                    r_row     <= r_row + ROW_W'(1);
                    r_row_sel <= (r_row_sel == 2'd2) ? 2'd0 : r_row_sel + 2'd1;
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end

            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------ datapath controls
    // Strobes follow the accept by one cycle; a bubble simply deasserts them.
    // Address and buffer select hold their last value between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lb_wr_en  <= 1'b0;
            r_win_shift <= 1'b0;
            r_lb_sel    <= '0;
            r_lb_addr   <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_lb_wr_en  <= w_accept;
            r_win_shift <= w_accept;
            if (w_accept) begin
                r_lb_sel  <= r_row_sel;
                r_lb_addr <= ADDR_W'(r_col);
            end
            r_vld_pipe  <= {r_vld_pipe[PIPE_LAT-1:0],  w_accept && w_interior};
            r_last_pipe <= {r_last_pipe[PIPE_LAT-1:0], w_accept && w_last_pix};
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign lb_wr_en  = r_lb_wr_en;
    assign win_shift = r_win_shift;
    assign lb_sel    = r_lb_sel;
    assign lb_addr   = r_lb_addr;
    assign win_valid = r_vld_pipe[0];
    assign out_valid = r_vld_pipe[PIPE_LAT];
    assign out_last  = r_last_pipe[PIPE_LAT];

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_ctrl
//   Two controller instances (4x4 with latency 2, 5x3 with latency 1) share
//   start/in_valid/rst. A per-instance model derives every output from the
//   pixel index of each accept (row = n / W, col = n % W) and a per-cycle
//   history of interior flags; a negedge process compares every output each
//   cycle. Per-frame totals and the first-result latency are pinned to
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sobel_window_ctrl;

    localparam int WP   [2] = '{4, 5};
    localparam int HP   [2] = '{4, 3};
    localparam int LP   [2] = '{2, 1};
    // Hand-computed per-frame expectations.
    localparam int FR_WR[2] = '{16, 15};
    localparam int FR_OV[2] = '{4, 3};
    localparam int K1ST [2] = '{11, 13};   // accept number of first interior pixel

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;

    always #5 clk = ~clk;

    logic       in_ready_o [2];
    logic       lb_wr_en_o [2];
    logic [1:0] lb_sel_o   [2];
    logic [5:0] lb_addr_o  [2];
    logic       win_shift_o[2];
    logic       win_valid_o[2];
    logic       out_valid_o[2];
    logic       out_last_o [2];
    logic       busy_o     [2];
    logic       done_o     [2];

    sobel_window_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(6), .PIPE_LAT(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_o[0]), .lb_wr_en(lb_wr_en_o[0]), .lb_sel(lb_sel_o[0]),
        .lb_addr(lb_addr_o[0]), .win_shift(win_shift_o[0]), .win_valid(win_valid_o[0]),
        .out_valid(out_valid_o[0]), .out_last(out_last_o[0]), .busy(busy_o[0]),
        .done(done_o[0]));

    sobel_window_ctrl #(.IMG_W(5), .IMG_H(3), .ADDR_W(6), .PIPE_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_o[1]), .lb_wr_en(lb_wr_en_o[1]), .lb_sel(lb_sel_o[1]),
        .lb_addr(lb_addr_o[1]), .win_shift(win_shift_o[1]), .win_valid(win_valid_o[1]),
        .out_valid(out_valid_o[1]), .out_last(out_last_o[1]), .busy(busy_o[1]),
        .done(done_o[1]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d want %0d", nm, k, act, exp);
        end
    endtask

    // ------------------------------------------------------------- model
    // mode: 0 idle, 1 accepting, 2 draining, 3 end-of-frame
    int  cyc = 0;
    int  m_mode[2];
    int  m_n   [2];
    int  m_fl  [2];
    bit  m_acc;
    bit  e_rdy [2], e_wr[2], e_wv[2], e_wl[2], e_ov[2], e_ol[2], e_busy[2], e_done[2];
    int  e_addr[2], e_sel[2];
    bit  h_wv  [2][64];
    bit  h_wl  [2][64];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = 0; m_n[k] = 0; m_fl[k] = 0;
                e_rdy[k] = 0; e_wr[k] = 0; e_wv[k] = 0; e_wl[k] = 0;
                e_ov[k] = 0; e_ol[k] = 0; e_busy[k] = 0; e_done[k] = 0;
                e_addr[k] = 0; e_sel[k] = 0;
                for (int j = 0; j < 64; j++) begin
                    h_wv[k][j] = 0;
                    h_wl[k][j] = 0;
                end
            end else begin
                m_acc = (m_mode[k] == 1) && in_valid;
                e_wr[k] = m_acc;
                if (m_acc) begin
                    e_addr[k] = m_n[k] % WP[k];
                    e_sel[k]  = (m_n[k] / WP[k]) % 3;
                    e_wv[k]   = ((m_n[k] / WP[k]) >= 2) && ((m_n[k] % WP[k]) >= 2);
                    e_wl[k]   = (m_n[k] == WP[k] * HP[k] - 1);
                end else begin
                    e_wv[k] = 0;
                    e_wl[k] = 0;
                end
                h_wv[k][cyc % 64] = e_wv[k];
                h_wl[k][cyc % 64] = e_wl[k];
                e_ov[k] = h_wv[k][(cyc + 64 - LP[k]) % 64];
                e_ol[k] = h_wl[k][(cyc + 64 - LP[k]) % 64];
                case (m_mode[k])
                    0: if (start) begin m_mode[k] = 1; m_n[k] = 0; end
                    1: if (m_acc) begin
                           m_n[k]++;
                           if (m_n[k] == WP[k] * HP[k]) begin m_mode[k] = 2; m_fl[k] = 0; end
                       end
                    2: begin
                           m_fl[k]++;
                           if (m_fl[k] == LP[k] + 1) m_mode[k] = 3;
                       end
                    default: m_mode[k] = 0;
                endcase
                e_rdy[k]  = (m_mode[k] == 1);
                e_busy[k] = (m_mode[k] != 0);
                e_done[k] = (m_mode[k] == 3);
            end
        end
    end

    // ----------------------------------------------------------- compare
    int fr_wr[2], fr_ov[2], fr_last[2], kcyc[2], done_cnt[2];

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                check("in_ready",  k, int'(in_ready_o[k]),  int'(e_rdy[k]));
                check("lb_wr_en",  k, int'(lb_wr_en_o[k]),  int'(e_wr[k]));
                check("win_shift", k, int'(win_shift_o[k]), int'(e_wr[k]));
                check("win_valid", k, int'(win_valid_o[k]), int'(e_wv[k]));
                check("out_valid", k, int'(out_valid_o[k]), int'(e_ov[k]));
                check("out_last",  k, int'(out_last_o[k]),  int'(e_ol[k]));
                check("busy",      k, int'(busy_o[k]),      int'(e_busy[k]));
                check("done",      k, int'(done_o[k]),      int'(e_done[k]));
                if (e_wr[k]) begin
                    check("lb_addr", k, int'(lb_addr_o[k]), e_addr[k]);
                    check("lb_sel",  k, int'(lb_sel_o[k]),  e_sel[k]);
                end
                if (!busy_o[k]) begin
                    fr_wr[k] = 0; fr_ov[k] = 0; fr_last[k] = 0;
                end else begin
                    if (lb_wr_en_o[k]) begin
                        fr_wr[k]++;
                        if (fr_wr[k] == K1ST[k]) kcyc[k] = cyc;
                    end
                    if (out_valid_o[k]) begin
                        if (fr_ov[k] == 0) check("first_lat", k, cyc - kcyc[k], LP[k]);
                        fr_ov[k]++;
                    end
                    if (out_last_o[k]) fr_last[k]++;
                    if (done_o[k]) begin
                        done_cnt[k]++;
                        check("frame_writes",  k, fr_wr[k],   FR_WR[k]);
                        check("frame_results", k, fr_ov[k],   FR_OV[k]);
                        check("frame_last",    k, fr_last[k], 1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            check(nm, k, int'({in_ready_o[k], lb_wr_en_o[k], lb_sel_o[k], lb_addr_o[k],
                               win_shift_o[k], win_valid_o[k], out_valid_o[k],
                               out_last_o[k], busy_o[k], done_o[k]}), 0);
        end
    endtask

    // mode 0: continuous, 1: alternate 1/0, 2: random with stray start pulses
    task automatic run_frame(input int mode);
        bit finished;
        finished = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int it = 0; it < 500; it++) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (it % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2 && busy_o[0] && busy_o[1])
                start = ($urandom_range(0, 5) == 0);
            else
                start = 1'b0;
            tick();
            if (!busy_o[0] && !busy_o[1]) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("frame_timeout", mode, int'(finished), 1);
        tick();
    endtask

    initial begin
        int base;
        bit ok;
        repeat (3) tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();
        check_all_zero("idle_state");

        // source pushing before start: nothing may be accepted
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;

        run_frame(0);
        run_frame(1);
        run_frame(2);

        // reset in the middle of a frame
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        run_frame(0);

        // start held high: back-to-back frames
        base = done_cnt[0];
        ok = 0;
        start = 1'b1;
        for (int it = 0; it < 800; it++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            tick();
            if (done_cnt[0] >= base + 2) begin
                ok = 1;
                break;
            end
        end
        check("held_start_frames", 0, int'(ok), 1);
        start = 1'b0;
        ok = 0;
        for (int it = 0; it < 200; it++) begin
            in_valid = ($urandom_range(0, 1) != 0);
            tick();
            if (!busy_o[0] && !busy_o[1]) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        check("drain_timeout", 0, int'(ok), 1);
        tick();

        for (int f = 0; f < 3; f++) run_frame(2);
        run_frame(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
